// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the register-rename stage and its free list.
package rename_stage_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;
    localparam int PREG_W    = $clog2(PHYS_REGS);
    localparam int AREG_W    = $clog2(ARCH_REGS);
    localparam int FL_IDX_W  = $clog2(FL_DEPTH);

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [AREG_W-1:0]   areg_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;
    typedef logic [FL_IDX_W:0]   fl_cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        areg_t       rs1;
        areg_t       rs2;
        areg_t       rd;
        logic        regwrite;
    } decode_data;

    typedef struct packed {
        logic [31:0] pc;
        preg_t       ps1;
        preg_t       ps2;
        preg_t       pd;
        preg_t       old_pd;
        areg_t       rd;
        logic        regwrite;
    } rename_data;

    // Circular index advance; written out so a non-power-of-two depth still wraps correctly.
    function automatic fl_idx_t fl_next(input fl_idx_t idx);
        return (idx == fl_idx_t'(FL_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of free physical registers, preloaded with the registers above the architectural range.
module free_list
    import rename_stage_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    pop,
    input  logic    push,
    input  preg_t   push_preg,
    output preg_t   head_preg,
    output fl_cnt_t count,
    output logic    empty
);

    preg_t   mem [FL_DEPTH];
    fl_idx_t head;
    fl_idx_t tail;
    logic    full;
    logic    do_pop;
    logic    do_push;

    assign full      = (count == fl_cnt_t'(FL_DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && !full;
    assign head_preg = mem[head];

    // A push into a full list would overwrite a live entry, so it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= preg_t'(ARCH_REGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= fl_cnt_t'(FL_DEPTH);
        end else begin
            assert (!(push && full));
            if (do_push) begin
                mem[tail] <= push_preg;
                tail      <= fl_next(tail);
            end
            if (do_pop) begin
                head <= fl_next(head);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: maps architectural sources/destination to physical registers via a RAT and free list.
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  decode_data data_in,
    output logic       ready_in,
    input  logic       ready_out,
    output logic       valid_out,
    output rename_data data_out,
    input  logic       free_valid,
    input  preg_t      free_preg
);

    preg_t      rat [ARCH_REGS];
    preg_t      fl_head;
    fl_cnt_t    fl_count;
    logic       fl_empty;
    logic       slot_free;
    logic       accept;
    logic       alloc;
    rename_data next_out;

    // Stall on an empty free list even for non-allocating instructions, so ready never depends on data_in.
    assign slot_free = !valid_out || ready_out;
    assign ready_in  = slot_free && !fl_empty && !reset;
    assign accept    = valid_in && ready_in;
    assign alloc     = data_in.regwrite && (data_in.rd != '0);

    always_comb begin
        next_out          = '0;
        next_out.pc       = data_in.pc;
        next_out.ps1      = rat[data_in.rs1];
        next_out.ps2      = rat[data_in.rs2];
        next_out.rd       = data_in.rd;
        next_out.regwrite = data_in.regwrite;
        if (alloc) begin
            next_out.pd     = fl_head;
            next_out.old_pd = rat[data_in.rd];
        end
    end

    free_list u_free_list (
        .clk       (clk),
        .reset     (reset),
        .pop       (accept && alloc),
        .push      (free_valid && (free_preg != '0)),
        .push_preg (free_preg),
        .head_preg (fl_head),
        .count     (fl_count),
        .empty     (fl_empty)
    );

    // Sources were read from the pre-update table above, so rs == rd sees the old mapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= preg_t'(i);
            end
        end else begin
            assert (fl_count <= fl_cnt_t'(FL_DEPTH));
            if (accept && alloc) begin
                rat[data_in.rd] <= fl_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (accept) begin
            valid_out <= 1'b1;
            data_out  <= next_out;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage directly downstream of the post-Decode skid buffer. It takes the slot where the testbench currently consumes decoded instructions.
- Consumes `decode_data` via valid/ready and maps architectural rs1/rs2/rd onto physical registers using a RAT and a circular free list.
- Emits `rename_data` to the future dispatch/ROB stage through a one-entry output register.
- A commit-side port returns freed physical registers to the free list.

Parameters:
- ARCH_REGS, 32: number of architectural registers. x0 is never renamed.
- PHYS_REGS, 64: number of physical registers. PREG_W = $clog2(PHYS_REGS) = 6.
- FL_DEPTH, PHYS_REGS-ARCH_REGS (32): free-list capacity.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream (decode skid) data valid.
- data_in  in  decode_data  decoded instruction; fields used: pc, rs1, rs2, rd, regwrite.
- ready_in  out  1  this stage accepts data_in this cycle.
- ready_out  in  1  downstream ready.
- valid_out  out  1  data_out valid.
- data_out  out  rename_data  fields: pc, ps1, ps2, pd, old_pd, rd (arch), regwrite.
- free_valid  in  1  commit returns a physical register this cycle.
- free_preg  in  PREG_W  physical register being freed.

Behaviour:
- Reset (synchronous, while reset=1):
  - RAT[i] = i for i = 0..31.
  - Free list holds p32..p63 in order; head = 0, tail = 0, count = 32.
  - valid_out = 0; data_out = all zeros.
  - ready_in is low while reset is high.
- Allocation condition: alloc = regwrite && rd != 0.
- Output slot free: slot_free = !valid_out || ready_out.
- ready_in = slot_free && (count != 0) && !reset.
  - Conservative rule: ready_in drops whenever the free list is empty, even for instructions that need no allocation.
  - ready_in does not depend on data_in.
- Accept condition: accept = valid_in && ready_in.
- On accept, the output register loads at the next edge (latency 1 cycle, throughput 1/cycle):
  - ps1 = RAT[rs1] and ps2 = RAT[rs2], read before this instruction's RAT update. If rs == rd in the same instruction, the source gets the old mapping.
  - If alloc: pd = free list head entry, old_pd = RAT[rd], RAT[rd] <= pd, head++ (mod FL_DEPTH), count--.
  - If !alloc: pd = 0, old_pd = 0; RAT and free list are unchanged.
  - pc, rd and regwrite pass through unchanged.
- Back-to-back accepts: the second instruction sees the RAT written by the first, because both the RAT write and the output register update happen at the same edge.
- Output register control:
  - Holds data and valid while valid_out && !ready_out.
  - Clears valid_out when ready_out && !accept.
  - Loads new data when accept; pass-through when ready_out is high and the slot is occupied.
- Free port:
  - free_valid && free_preg != 0: write free_preg at tail, tail++ (mod FL_DEPTH), count++.
  - free_preg == 0: ignored.
- Simultaneous pop and push in one cycle: count unchanged; head and tail both advance.
- A register freed in cycle N is allocatable from cycle N+1 (no same-cycle bypass). ready_in uses the registered count.
- Wrap-around: head and tail wrap from FL_DEPTH-1 to 0.
- Overflow (push when count == FL_DEPTH) is illegal:
  - The push is dropped.
  - A simulation-only assertion fires.
- reset asserted mid-stream discards the in-flight output and all RAT and free-list state.

Decomposition:
- types_pkg additions:
  - ARCH_REGS and PHYS_REGS constants.
  - preg_t (logic [PREG_W-1:0]).
  - rename_data struct (pc, ps1, ps2, pd, old_pd, rd, regwrite).
- Sub-module free_list: circular FIFO of preg_t with synchronous reset preload (p32..p63), pop/push ports, count and empty outputs.
- The RAT stays inline in rename_stage.

Test Plan:
- Reset then idle: valid_out = 0, ready_in = 1, internal count = 32, RAT[5] = 5.
- add x3,x1,x2 (regwrite=1), ready_out=1: one cycle later valid_out = 1, ps1 = 1, ps2 = 2, pd = 32, old_pd = 3.
- Dependency chain in consecutive cycles:
  - add x3,x1,x2 then add x4,x3,x3.
  - Second instruction: ps1 = ps2 = 32, pd = 33, old_pd = 4.
  - Then addi x3,x3,1: ps1 = 32, pd = 34, old_pd = 32.
- rd = x0 or a store (regwrite = 0): pd = 0, old_pd = 0, count unchanged, RAT unchanged.
- Exhaustion and refill:
  - 32 allocating instructions: ready_in goes low after the 32nd accept.
  - free_valid = 1 with free_preg = 5 in cycle N: ready_in = 1 in cycle N+1; next allocation gets pd = 5.
  - Continued freeing drives the head index across the 31 -> 0 wrap.
- Backpressure: hold ready_out = 0 for 3 cycles with valid_in = 1. data_out stays stable, ready_in = 0, and no RAT or free-list change occurs. On release, one instruction drains per cycle in order.
